// File: rtl/log_dump_if.sv
// Log readback bus: memory read port plus the byte stream toward the debug link.
// master = readback engine, slave = log storage / byte transmitter side.
interface log_dump_if #(
    parameter int ADDR_WIDTH  = 8,
    parameter int ENTRY_WIDTH = 76
);
    logic                   mem_rd_en_out;
    logic [ADDR_WIDTH-1:0]  mem_rd_addr_out;
    logic [ENTRY_WIDTH-1:0] mem_rd_data_in;
    logic [7:0]             byte_out;
    logic                   byte_valid_out;
    logic                   byte_ready_in;

    modport master (
        output mem_rd_en_out,
        output mem_rd_addr_out,
        input  mem_rd_data_in,
        output byte_out,
        output byte_valid_out,
        input  byte_ready_in
    );

    modport slave (
        input  mem_rd_en_out,
        input  mem_rd_addr_out,
        output mem_rd_data_in,
        input  byte_out,
        input  byte_valid_out,
        output byte_ready_in
    );
endinterface

// File: rtl/log_dump.sv
// Log readback engine: reads the 76-bit log entries one at a time and streams
// each one out as ten bytes, MSB first, over a valid/ready byte interface.
//
// state | meaning
// IDLE  | waiting for dump_start_in
// READ  | one-cycle read strobe at the current address
// WAIT  | read data arrives, loaded into the byte shift register
// SEND  | ten byte handshakes for the current entry
// DONE  | one-cycle completion pulse
module log_dump #(
    parameter int DATA_SIZE  = 32,
    parameter int TAG_SIZE   = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  dump_start_in,
    input  logic                  abort_in,
    input  logic [ADDR_WIDTH:0]   entry_count_in,
    log_dump_if.master            bus,
    output logic                  busy_out,
    output logic                  done_out,
    output logic [ADDR_WIDTH:0]   entries_sent_out
);
    localparam int ENTRY_WIDTH = 4 + DATA_SIZE + DATA_SIZE + TAG_SIZE;
    localparam int SHIFT_W     = ENTRY_WIDTH + 4;
    localparam int MEM_DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] MAX_COUNT = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [3:0] LAST_BYTE = 4'(SHIFT_W / 8 - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        WAIT = 3'd2,
        SEND = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [ADDR_WIDTH:0]    count_q, count_d;
    logic [ADDR_WIDTH:0]    sent_q, sent_d;
    logic [SHIFT_W-1:0]     shreg_q, shreg_d;
    logic [3:0]             idx_q, idx_d;
    logic                   rd_en_q, rd_en_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   hs;
    logic [ADDR_WIDTH:0]    sent_inc;

    assign hs       = valid_q && bus.byte_ready_in;
    assign sent_inc = sent_q + 1'b1;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        sent_d  = sent_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;

        unique case (state_q)
            IDLE: begin
                if (dump_start_in) begin
                    sent_d = '0;
                    if (entry_count_in == '0) begin
                        state_d = DONE;
                    end else begin
                        count_d = (entry_count_in > MAX_COUNT) ? MAX_COUNT : entry_count_in;
                        addr_d  = '0;
                        state_d = READ;
                    end
                end
            end
            READ: state_d = WAIT;
            WAIT: begin
                shreg_d = {4'b0000, bus.mem_rd_data_in};
                idx_d   = '0;
                state_d = SEND;
            end
            SEND: begin
                if (hs) begin
                    shreg_d = shreg_q << 8;
                    if (idx_q == LAST_BYTE) begin
                        sent_d = sent_inc;
                        // Address only advances when another read follows, so
                        // a full-depth dump never wraps back to 0.
                        if (sent_inc == count_q) begin
                            state_d = DONE;
                        end else begin
                            addr_d  = addr_q + 1'b1;
                            state_d = READ;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Abort beats a same-cycle handshake: nothing from this cycle is kept.
        if (abort_in && state_q != IDLE) begin
            state_d = IDLE;
            addr_d  = addr_q;
            count_d = count_q;
            sent_d  = sent_q;
            shreg_d = shreg_q;
            idx_d   = idx_q;
        end

        rd_en_d = (state_d == READ);
        valid_d = (state_d == SEND);
        busy_d  = (state_d == READ) || (state_d == WAIT) || (state_d == SEND);
        done_d  = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            count_q <= '0;
            sent_q  <= '0;
            shreg_q <= '0;
            idx_q   <= '0;
            rd_en_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            sent_q  <= sent_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            rd_en_q <= rd_en_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.mem_rd_en_out   = rd_en_q;
    assign bus.mem_rd_addr_out = addr_q;
    assign bus.byte_out        = shreg_q[SHIFT_W-1 -: 8];
    assign bus.byte_valid_out  = valid_q;
    assign busy_out            = busy_q;
    assign done_out            = done_q;
    assign entries_sent_out    = sent_q;
endmodule
